// File: rtl/rs_cmd_sequencer.sv
// Command sequencer for a clocked RS flop: turns one-cycle set/clear requests
// into timed S/R pulses, tracks the target state on Qin and checks q_fb after each command.
module rs_cmd_sequencer #(
   parameter int unsigned PULSE_CYCLES = 1,
   parameter int unsigned GAP_CYCLES   = 1,
   parameter int unsigned CNT_W        = 8,
   parameter logic        RESET_Q      = 1'b0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             set_req,
   input  logic             clr_req,
   input  logic             q_fb,
   output logic             S,
   output logic             R,
   output logic             Qin,
   output logic             busy,
   output logic             done,
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt,
   output logic             mismatch
);

   localparam int unsigned      TMR_W      = 8;
   localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [TMR_W-1:0]   timer, timer_nxt;
   logic               s_nxt, r_nxt, qin_nxt, done_nxt, conflict_nxt, mismatch_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // State and registered outputs; S/R clear asynchronously on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         timer        <= '0;
         S            <= 1'b0;
         R            <= 1'b0;
         Qin          <= RESET_Q;
         busy         <= 1'b0;
         done         <= 1'b0;
         conflict     <= 1'b0;
         conflict_cnt <= '0;
         mismatch     <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         S            <= s_nxt;
         R            <= r_nxt;
         Qin          <= qin_nxt;
         busy         <= (state_nxt != IDLE);
         done         <= done_nxt;
         conflict     <= conflict_nxt;
         conflict_cnt <= cnt_nxt;
         mismatch     <= mismatch_nxt;
      end
   end

   // Next-state logic; S and R are only ever set in mutually exclusive branches.
   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      s_nxt        = 1'b0;
      r_nxt        = 1'b0;
      qin_nxt      = Qin;
      done_nxt     = 1'b0;
      conflict_nxt = 1'b0;
      cnt_nxt      = conflict_cnt;
      mismatch_nxt = mismatch;

      case (state)
         IDLE: begin
            if (set_req && clr_req) begin
               conflict_nxt = 1'b1;
               if (conflict_cnt != CNT_MAX) begin
                  cnt_nxt = conflict_cnt + CNT_W'(1);
               end
            end else if (set_req) begin
               state_nxt = DRIVE;
               s_nxt     = 1'b1;
               qin_nxt   = 1'b1;
               timer_nxt = PULSE_LOAD;
            end else if (clr_req) begin
               state_nxt = DRIVE;
               r_nxt     = 1'b1;
               qin_nxt   = 1'b0;
               timer_nxt = PULSE_LOAD;
            end
         end

         DRIVE: begin
            if (timer == '0) begin
               state_nxt = GAP;
               timer_nxt = GAP_LOAD;
            end else begin
               s_nxt     = S;
               r_nxt     = R;
               timer_nxt = timer - TMR_W'(1);
            end
         end

         GAP: begin
            if (timer == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               if (q_fb != Qin) begin
                  mismatch_nxt = 1'b1;
               end
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/rs_cmd_sequencer.md
Name: rs_cmd_sequencer

Overview:
Upstream command stage for the team's clocked RS flip-flop. Converts one-cycle set/clear requests into properly timed S/R drive pulses, and drives Qin with the tracked target state so the flop holds its value between commands. It never drives S=R=1. It checks the flop's fed-back Qout against the tracked state after every command.

Parameters:
PULSE_CYCLES, 1, cycles S or R is held high per command (1..255)
GAP_CYCLES, 1, cycles S=R=0 enforced after each pulse before done (1..255)
CNT_W, 8, width of the saturating conflict counter
RESET_Q, 0, tracked state (Qin) value after reset

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
set_req  input  1  request to set flop (sampled only in IDLE)
clr_req  input  1  request to clear flop (sampled only in IDLE)
q_fb  input  1  Qout fed back from downstream RS flop
S  output  1  registered set drive to RS flop
R  output  1  registered reset drive to RS flop
Qin  output  1  registered tracked state, hold value for RS flop
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on return to IDLE after a command
conflict  output  1  one-cycle pulse, set_req and clr_req both high in IDLE
conflict_cnt  output  CNT_W  saturating count of conflicts
mismatch  output  1  sticky: q_fb differed from Qin at a done cycle

Behaviour:
- Clock/reset: one clock, "clock". Reset is asynchronous and active-low, "reset_n".
- Reset values: state=IDLE, S=0, R=0, Qin=RESET_Q, busy=0, done=0, conflict=0, conflict_cnt=0, mismatch=0, internal timer=0.
- Reset asserted mid-operation: S/R drop to 0 immediately (asynchronously), and any in-flight command is abandoned.
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - set_req=1, clr_req=0 at edge t -> DRIVE. S=1 and Qin=1 from edge t. Timer=PULSE_CYCLES-1.
  - clr_req=1, set_req=0 -> same, with R=1 and Qin=0.
  - Both high -> stay IDLE. conflict=1 for one cycle. conflict_cnt increments and saturates at 2^CNT_W-1. S/R stay 0.
  - Neither high -> stay IDLE.
- DRIVE:
  - S (or R) stays high for exactly PULSE_CYCLES cycles.
  - Timer decrements each edge. When timer=0 at an edge -> GAP, S=R=0, timer=GAP_CYCLES-1.
- GAP:
  - S=R=0, Qin holds the new state.
  - When timer=0 at an edge -> IDLE, done=1 for that one cycle.
  - At that same edge, mismatch is set if q_fb != Qin. mismatch is cleared only by reset.
- Qin updates on DRIVE entry, not at pulse end. The flop therefore samples S=R=0 with Qin already equal to the target.
- Command latency: request at edge t -> done high after edge t+PULSE_CYCLES+GAP_CYCLES. Back-to-back throughput is one command per PULSE_CYCLES+GAP_CYCLES+1 cycles.
- Requests while busy=1 (DRIVE/GAP) are ignored and not queued; conflicts while busy are not counted.
- Invariant: S&R==0 in every cycle, including during reset.
- A request equal to the current state (e.g. set when Qin=1) is still executed in full.

Test Plan:
- Reset, no requests, 10 cycles -> S=R=0, Qin=RESET_Q(0), busy=0, done=0, conflict_cnt=0, mismatch=0.
- PULSE_CYCLES=2, GAP_CYCLES=1; set_req one cycle at edge 3 -> S=1 after edges 3..4, S=0 at edge 5, done=1 after edge 6 only, Qin=1 from edge 3; with the RS flop connected, q_fb=1 and mismatch=0.
- Then clr_req pulse -> R=1 for 2 cycles, Qin=0, done after 4 cycles, q_fb=0. Throughout, assert S&R never 1.
- set_req=clr_req=1 in IDLE -> conflict pulses once, conflict_cnt=1, S=R=0, busy=0. With CNT_W=2 and 5 conflicts -> conflict_cnt saturates at 3.
- clr_req pulsed during DRIVE of a set -> ignored: R stays 0, final Qin=1, exactly one done pulse.
- Force q_fb=0 during a set command -> mismatch=1 at the done cycle and stays 1 through later correct commands until reset_n=0.
- Assert reset_n=0 mid-DRIVE, asynchronously (between edges) -> S falls immediately, all outputs return to reset values, and a new command after release completes normally.
